// File: rtl/alu_pkg.sv
// Shared definitions for the sequenced ALU loader: funct codes, FSM states,
// flag and button bit positions.
package alu_pkg;

  // MIPS funct codes, 6 bits wide; users resize them to their opcode width.
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_XOR = 6'b100110;
  localparam logic [5:0] F_NOR = 6'b100111;
  localparam logic [5:0] F_SRL = 6'b000010;
  localparam logic [5:0] F_SRA = 6'b000011;

  // Load sequence; the encoding is also the value shown on the stage output.
  typedef enum logic [1:0] {
    LOAD_A  = 2'd0,
    LOAD_B  = 2'd1,
    LOAD_OP = 2'd2,
    EXEC    = 2'd3
  } state_e;

  localparam int FLAG_C = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_Z = 0;

  localparam int BTN_A  = 2;
  localparam int BTN_B  = 1;
  localparam int BTN_OP = 0;

endpackage

// File: rtl/button_conditioner.sv
// Synchroniser, debounce counter and single-shot press pulse for one button.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic button,
  output logic pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_FIRE = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync0, sync1;
  logic          settle0, settle1;
  logic          lockout;
  logic [CW-1:0] cnt;

  // Synchronise, count stable-high cycles, and fire once when the count saturates.
  // NOTE: every state flop here uses <= so all of them sample pre-edge values;
  // a blocking assignment would let sync1 see this edge's sync0 and skip a stage.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync0   <= 1'b0;
      sync1   <= 1'b0;
      settle0 <= 1'b0;
      settle1 <= 1'b0;
      lockout <= 1'b1;
      cnt     <= '0;
      pulse   <= 1'b0;
    end else begin
      sync0   <= button;
      sync1   <= sync0;
      // settle1 marks when sync1 carries a real post-reset sample, so a button
      // held through reset stays locked out until it is seen low.
      settle0 <= 1'b1;
      settle1 <= settle0;
      if (settle1 && !sync1) lockout <= 1'b0;
      if (!sync1)              cnt <= '0;
      else if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
      pulse <= sync1 && (cnt == CNT_FIRE) && !lockout;
    end
  end

endmodule

// File: rtl/alu_sequenced_loader.sv
// Order-enforced A/B/Op loader with a one-cycle execution stage driving the LEDs.
module alu_sequenced_loader
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH      = 6,
  parameter int OP_WIDTH        = 6,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] switches,
  input  logic [2:0]            buttons,
  output logic [DATA_WIDTH-1:0] LEDS,
  output logic [2:0]            flags,
  output logic [1:0]            stage,
  output logic                  done,
  output logic                  err
);

  localparam int SW = $clog2(DATA_WIDTH);

  logic [2:0]            press;
  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] a_q, b_q;
  logic [OP_WIDTH-1:0]   op_q;
  logic                  load_a, load_b, load_op, err_set, err_clr, exec;
  logic [2:0]            want;
  logic                  multi;

  logic [DATA_WIDTH-1:0] alu_res;
  logic                  alu_c, alu_v, alu_bad;
  logic [DATA_WIDTH:0]   sum_ext, diff_ext;
  logic [SW-1:0]         shamt;

  for (genvar i = 0; i < 3; i++) begin : g_btn
    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond (
      .clock  (clock),
      .reset  (reset),
      .button (buttons[i]),
      .pulse  (press[i])
    );
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= LOAD_A;
    else       state_q <= state_d;
  end

  // Next state: accept only the single expected press; anything else flags err.
  // NOTE: every output gets a default first so no path leaves one unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    load_a  = 1'b0;
    load_b  = 1'b0;
    load_op = 1'b0;
    err_set = 1'b0;
    err_clr = 1'b0;
    want    = 3'b000;
    multi   = (press[0] & press[1]) | (press[0] & press[2]) | (press[1] & press[2]);
    case (state_q)
      LOAD_A:  want = 3'b100;
      LOAD_B:  want = 3'b010;
      LOAD_OP: want = 3'b001;
      default: want = 3'b000;
    endcase
    if (state_q == EXEC) begin
      state_d = LOAD_A;
      if (|press) err_set = 1'b1;
    end else if (|press) begin
      if (multi || press != want) begin
        err_set = 1'b1;
      end else begin
        err_clr = 1'b1;
        case (state_q)
          LOAD_A:  begin load_a  = 1'b1; state_d = LOAD_B;  end
          LOAD_B:  begin load_b  = 1'b1; state_d = LOAD_OP; end
          default: begin load_op = 1'b1; state_d = EXEC;    end
        endcase
      end
    end
  end

  assign exec  = (state_q == EXEC);
  assign stage = state_q;

  // ALU: result plus carry/borrow and signed overflow for the current operands.
  always_comb begin
    alu_res  = '0;
    alu_c    = 1'b0;
    alu_v    = 1'b0;
    alu_bad  = 1'b0;
    sum_ext  = {1'b0, a_q} + {1'b0, b_q};
    diff_ext = {1'b0, a_q} - {1'b0, b_q};
    shamt    = b_q[SW-1:0];
    case (op_q)
      OP_WIDTH'(F_ADD): begin
        alu_res = sum_ext[DATA_WIDTH-1:0];
        alu_c   = sum_ext[DATA_WIDTH];
        alu_v   = (a_q[DATA_WIDTH-1] == b_q[DATA_WIDTH-1]) &&
                  (alu_res[DATA_WIDTH-1] != a_q[DATA_WIDTH-1]);
      end
      OP_WIDTH'(F_SUB): begin
        alu_res = diff_ext[DATA_WIDTH-1:0];
        alu_c   = diff_ext[DATA_WIDTH];
        alu_v   = (a_q[DATA_WIDTH-1] != b_q[DATA_WIDTH-1]) &&
                  (alu_res[DATA_WIDTH-1] != a_q[DATA_WIDTH-1]);
      end
      OP_WIDTH'(F_AND): alu_res = a_q & b_q;
      OP_WIDTH'(F_OR):  alu_res = a_q | b_q;
      OP_WIDTH'(F_XOR): alu_res = a_q ^ b_q;
      OP_WIDTH'(F_NOR): alu_res = ~(a_q | b_q);
      // Shifts past the width naturally give 0 / all sign bits.
      OP_WIDTH'(F_SRL): alu_res = a_q >> shamt;
      OP_WIDTH'(F_SRA): alu_res = $unsigned($signed(a_q) >>> shamt);
      default:          alu_bad = 1'b1;
    endcase
  end

  // Operand registers, result/flag capture, done pulse and sticky error.
  always_ff @(posedge clock) begin
    if (reset) begin
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
      LEDS  <= '0;
      flags <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      if (load_a)  a_q  <= switches;
      if (load_b)  b_q  <= switches;
      if (load_op) op_q <= switches[OP_WIDTH-1:0];
      done <= exec;
      if (exec) begin
        LEDS          <= alu_res;
        flags[FLAG_C] <= alu_c;
        flags[FLAG_V] <= alu_v;
        flags[FLAG_Z] <= (alu_res == '0);
      end
      if (err_set || (exec && alu_bad)) err <= 1'b1;
      else if (err_clr)                 err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_sequenced_loader.sv
// Directed bench for alu_sequenced_loader with default parameters.
module tb_alu_sequenced_loader;
  import alu_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic [5:0] switches;
  logic [2:0] buttons;
  logic [5:0] LEDS;
  logic [2:0] flags;
  logic [1:0] stage;
  logic       done;
  logic       err;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [5:0] cap_leds;
  logic [2:0] cap_flags;

  alu_sequenced_loader dut (
    .clock    (clock),
    .reset    (reset),
    .switches (switches),
    .buttons  (buttons),
    .LEDS     (LEDS),
    .flags    (flags),
    .stage    (stage),
    .done     (done),
    .err      (err)
  );

  always #5 clock = ~clock;

  // Count done pulses and capture what the LEDs show while done is high.
  always @(negedge clock) begin
    if (done) begin
      done_cnt++;
      cap_leds  = LEDS;
      cap_flags = flags;
    end
  end

  typedef struct {
    logic [5:0] a;
    logic [5:0] b;
    logic [5:0] op;
    logic [5:0] leds;
    logic [2:0] flg;
    logic       e;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Hold the masked buttons for 'hold' cycles with switches at val, then let it settle.
  task automatic press(input logic [2:0] mask, input logic [5:0] val, input int hold);
    @(posedge clock); #1;
    switches = val;
    buttons  = mask;
    repeat (hold) @(posedge clock);
    #1 buttons = 3'b000;
    repeat (8) @(posedge clock);
    #1;
  endtask

  // Full A/B/Op sequence followed by result checks.
  task automatic run_vec(input int idx, input vec_t v);
    int base;
    press(3'b100, v.a, 10);
    press(3'b010, v.b, 10);
    base = done_cnt;
    press(3'b001, v.op, 10);
    check($sformatf("v%0d done_count", idx), done_cnt - base, 1);
    check($sformatf("v%0d leds_at_done", idx), cap_leds, v.leds);
    check($sformatf("v%0d flags_at_done", idx), cap_flags, v.flg);
    check($sformatf("v%0d leds_hold", idx), LEDS, v.leds);
    check($sformatf("v%0d stage", idx), stage, 0);
    check($sformatf("v%0d err", idx), err, v.e);
  endtask

  vec_t vecs[14];

  initial begin
    vecs[0]  = '{6'd15, 6'd20, F_ADD, 6'h23, 3'b010, 1'b0};
    vecs[1]  = '{6'd20, 6'd15, F_SUB, 6'h05, 3'b000, 1'b0};
    vecs[2]  = '{6'd15, 6'd20, F_AND, 6'h04, 3'b000, 1'b0};
    vecs[3]  = '{6'd15, 6'd20, F_OR,  6'h1F, 3'b000, 1'b0};
    vecs[4]  = '{6'd20, 6'd15, F_XOR, 6'h1B, 3'b000, 1'b0};
    vecs[5]  = '{6'd20, 6'd15, F_NOR, 6'h20, 3'b000, 1'b0};
    vecs[6]  = '{6'd20, 6'd20, F_SUB, 6'h00, 3'b001, 1'b0};
    vecs[7]  = '{6'd15, 6'd20, F_SUB, 6'h3B, 3'b100, 1'b0};
    vecs[8]  = '{6'h3F, 6'h01, F_ADD, 6'h00, 3'b101, 1'b0};
    vecs[9]  = '{6'h20, 6'd7,  F_SRA, 6'h3F, 3'b000, 1'b0};
    vecs[10] = '{6'h20, 6'd2,  F_SRL, 6'h08, 3'b000, 1'b0};
    vecs[11] = '{6'h20, 6'd2,  F_SRA, 6'h38, 3'b000, 1'b0};
    vecs[12] = '{6'h15, 6'h07, 6'h3F, 6'h00, 3'b001, 1'b1};
    vecs[13] = '{6'h1F, 6'h01, F_ADD, 6'h20, 3'b010, 1'b0};

    reset    = 1'b1;
    buttons  = 3'b000;
    switches = 6'h00;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("rst leds", LEDS, 0);
    check("rst flags", flags, 0);
    check("rst stage", stage, 0);
    check("rst done", done, 0);
    check("rst err", err, 0);
    check("rst a", dut.a_q, 0);
    repeat (5) @(posedge clock);

    // Press latency: high from edge k, register updates on edge k+6.
    @(posedge clock); #1;
    switches = 6'h2A;
    buttons  = 3'b100;
    repeat (6) @(posedge clock);
    #1 check("lat a_before", dut.a_q, 6'h00);
    @(posedge clock);
    #1 check("lat a_after", dut.a_q, 6'h2A);
    check("lat stage", stage, 1);
    repeat (4) @(posedge clock);
    #1 buttons = 3'b000;
    repeat (8) @(posedge clock);
    press(3'b010, 6'h14, 10);
    press(3'b001, F_ADD, 10);
    check("lat leds", LEDS, 6'h3E);

    // Wrong button, then two buttons together, in LOAD_A.
    press(3'b010, 6'h05, 10);
    check("wrong err", err, 1);
    check("wrong stage", stage, 0);
    press(3'b110, 6'h07, 10);
    check("multi err", err, 1);
    check("multi stage", stage, 0);
    check("multi a_kept", dut.a_q, 6'h2A);
    press(3'b100, 6'h11, 10);
    check("recover err", err, 0);
    check("recover stage", stage, 1);
    check("recover a", dut.a_q, 6'h11);
    press(3'b010, 6'h05, 10);
    press(3'b001, F_AND, 10);
    check("recover leds", LEDS, 6'h01);

    // Short glitch is filtered; a long hold loads exactly once.
    press(3'b100, 6'h33, 2);
    check("glitch stage", stage, 0);
    check("glitch err", err, 0);
    check("glitch a_kept", dut.a_q, 6'h11);
    press(3'b100, 6'h0C, 10);
    check("long stage", stage, 1);
    check("long err", err, 0);
    check("long a", dut.a_q, 6'h0C);
    press(3'b010, 6'h03, 10);
    press(3'b001, F_OR, 10);
    check("long leds", LEDS, 6'h0F);

    for (int i = 0; i < 14; i++) run_vec(i, vecs[i]);

    // Reset in the middle of a sequence.
    press(3'b100, 6'd15, 10);
    check("mid stage_before", stage, 1);
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    check("mid stage", stage, 0);
    check("mid leds", LEDS, 0);
    check("mid flags", flags, 0);
    check("mid a", dut.a_q, 0);
    repeat (5) @(posedge clock);
    run_vec(100, vecs[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_sequenced_loader.md
# alu_sequenced_loader

Parametrised front end and execution stage for the board-level ALU demo. Switches and three push buttons (load A, load B, load Op) drive a debounced, order-enforced load sequence. The block then executes one MIPS-funct-coded operation and holds the registered result and status flags on the LEDs. It replaces the unconditioned, any-order latch scheme with width-generic operands, filtered buttons, flags and error reporting.

## Interface

- DATA_WIDTH, 6: operand/result width (switch count used for A and B); minimum 4.
- OP_WIDTH, 6: opcode field width; the low OP_WIDTH switches are sampled for Op; requires OP_WIDTH ≤ DATA_WIDTH.
- DEBOUNCE_CYCLES, 4: consecutive synchronised-high cycles required to accept a press; 1 disables filtering.

- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; the polarity and synchronicity are fixed.
- switches  in  DATA_WIDTH  operand / opcode value.
- buttons  in  3  [2]=load A, [1]=load B, [0]=load Op; asynchronous, may bounce.
- LEDS  out  DATA_WIDTH  registered result.
- flags  out  3  [2]=carry/borrow, [1]=overflow, [0]=zero; registered with LEDS.
- stage  out  2  expected next input: 0=A, 1=B, 2=Op, 3=executing.
- done  out  1  one-cycle pulse when LEDS/flags update.
- err  out  1  sticky error; cleared by the next accepted press.

## Operation

- Each button: 2-flop synchroniser, then a saturating counter that counts while the synchronised level is high and clears when it is low. A press pulse fires once, in the cycle the counter reaches DEBOUNCE_CYCLES. The pulse cannot repeat until the button has gone low.
- FSM states: LOAD_A → LOAD_B → LOAD_OP → EXEC → LOAD_A.
  - LOAD_A: an A pulse latches switches into A and advances.
  - LOAD_B: a B pulse latches switches into B.
  - LOAD_OP: an Op pulse latches switches[OP_WIDTH-1:0] into Op.
  - EXEC: lasts exactly 1 cycle, computes, writes LEDS and flags, pulses done, then returns to LOAD_A.
- Error conditions: a pulse for the wrong button, two or more pulses in the same cycle, or any pulse during EXEC. In each case the press is ignored, err is set and the state is unchanged.
- Operations, where Op is the 6-bit funct zero-extended or truncated to OP_WIDTH:
  - 100000 ADD: carry is the unsigned carry-out; overflow is signed overflow.
  - 100010 SUB A−B: carry is the borrow (A<B unsigned); overflow is signed overflow.
  - 100100 AND, 100101 OR, 100110 XOR, 100111 NOR: carry and overflow are 0.
  - 000010 SRL: shift A by B[clog2(DATA_WIDTH)-1:0]; an amount ≥ DATA_WIDTH yields 0.
  - 000011 SRA: same shift amount; an amount ≥ DATA_WIDTH yields all sign bits.
  - Any other code: LEDS=0, carry and overflow 0, err=1.
- zero = (result == 0) for every operation, including undefined codes.
- The A, B and Op registers retain their values after EXEC; LEDS holds its value until the next EXEC.

## Timing

- Reset values: LEDS=0, flags=0, stage=0, done=0, err=0, A=B=Op=0, all counters and synchroniser flops 0.
- Press latency: if a button is high at rising edge k, the pulse is active during the cycle after edge k+1+DEBOUNCE_CYCLES. The operand register holds the new value after that cycle's closing edge. With the default of 4, the register updates on edge k+6.
- Switches are sampled in the pulse cycle only; switch changes at any other time have no effect.
- The Op pulse in cycle c is followed by EXEC in cycle c+1. LEDS, flags and done are visible from edge c+2; done falls at edge c+3.
- A high-glitch shorter than DEBOUNCE_CYCLES synchronised cycles produces no pulse and no err.
- Asserting reset mid-sequence aborts the sequence on the next edge with all reset values restored; a button held through reset must be released before it is accepted again.

## Structure

- Package alu_pkg: funct opcode localparams, the FSM state enum, and flag bit indices. The package is shared with the ALU core and the benches.
- One sub-module, button_conditioner (synchroniser + debounce + edge pulse, parameter DEBOUNCE_CYCLES), instantiated 3 times. The FSM and ALU datapath stay in the top module.

## Test plan

- Defaults; A=15, B=20, Op=100000 → LEDS=0x23, carry=0, overflow=1, zero=0, done one cycle, stage back to 0.
- A=20, B=15 with SUB → 5. Repeat with AND, OR, XOR and NOR on (15,20) / (20,15) → 4, 0x1F, 0x1B, 0x20 respectively. Also check SUB 20−20 → LEDS=0, zero=1.
- In LOAD_A, press B; then press A and B together → err=1, stage stays 0 and A is unchanged. A valid A press afterwards → err=0, stage=1.
- Hold load A high for 2 cycles (DEBOUNCE_CYCLES=4) → no load, no err. Hold it for 10 cycles → exactly one load.
- Op=111111 → LEDS=0, zero=1, err=1. SRA with A=0x20, B=7 → LEDS=0x3F. SRL with A=0x20, B=2 → 0x08.
- Load A=15, then assert reset for 1 cycle → stage=0, LEDS=0, A=0. The next full sequence executes correctly.
